// File: rtl/lr35902_oam_ctrl.sv
// OAM access sequencer: arbitrates DMA copy, PPU scan and CPU accesses onto the
// 256x8 sprite RAM through a two-clock strobe/release slot.
module lr35902_oam_ctrl #(
    parameter int unsigned OAM_SIZE     = 160,
    parameter int unsigned SETUP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [7:0]  cpu_adr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_done,
    input  logic        ppu_lock,
    input  logic        ppu_rd,
    input  logic [7:0]  ppu_adr,
    output logic [7:0]  ppu_dout,
    output logic        ppu_valid,
    input  logic        dma_trig,
    input  logic [7:0]  dma_page,
    output logic        dma_active,
    output logic [15:0] ext_adr,
    output logic        ext_rd,
    input  logic [7:0]  ext_din,
    output logic [7:0]  oam_adr,
    output logic [7:0]  oam_din,
    output logic        oam_read,
    output logic        oam_write,
    input  logic [7:0]  oam_dout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_STROBE  = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [2:0] D_IDLE  = 3'd0;
    localparam logic [2:0] D_SETUP = 3'd1;
    localparam logic [2:0] D_FETCH = 3'd2;
    localparam logic [2:0] D_LATCH = 3'd3;
    localparam logic [2:0] D_WRITE = 3'd4;

    localparam logic [1:0] OWN_DMA = 2'd0;
    localparam logic [1:0] OWN_PPU = 2'd1;
    localparam logic [1:0] OWN_CPU = 2'd2;

    localparam logic [7:0] LAST_IDX  = 8'(OAM_SIZE - 1);
    localparam logic [7:0] SETUP_INI = 8'(SETUP_CYCLES - 1);

    // Slot and output registers
    logic [1:0] slot_st_q, slot_st_d;
    logic [1:0] slot_own_q, slot_own_d;
    logic       slot_we_q, slot_we_d;
    logic [7:0] oam_adr_q, oam_adr_d;
    logic [7:0] oam_din_q, oam_din_d;
    logic       oam_read_q, oam_read_d;
    logic       oam_write_q, oam_write_d;
    logic [7:0] cpu_dout_q, cpu_dout_d;
    logic       cpu_done_q, cpu_done_d;
    logic [7:0] ppu_dout_q, ppu_dout_d;
    logic       ppu_valid_q, ppu_valid_d;

    // Pending requests
    logic       cpu_pend_q, cpu_pend_d;
    logic       cpu_we_q, cpu_we_d;
    logic [7:0] cpu_adr_q, cpu_adr_d;
    logic [7:0] cpu_din_q, cpu_din_d;
    logic       ppu_pend_q, ppu_pend_d;
    logic [7:0] ppu_adr_q, ppu_adr_d;

    // DMA engine
    logic [2:0]  dma_st_q, dma_st_d;
    logic [7:0]  dma_page_q, dma_page_d;
    logic [7:0]  dma_idx_q, dma_idx_d;
    logic [7:0]  dma_data_q, dma_data_d;
    logic        dma_active_q, dma_active_d;
    logic        restart_q, restart_d;
    logic [7:0]  setup_cnt_q, setup_cnt_d;
    logic [15:0] ext_adr_q, ext_adr_d;
    logic        ext_rd_q, ext_rd_d;

    logic       slot_idle;
    logic       cpu_req, cpu_any, cpu_blocked, cpu_grant, cpu_drop, cpu_sel_we;
    logic [7:0] cpu_sel_adr, cpu_sel_din;
    logic       ppu_any, ppu_grant, ppu_drop;
    logic [7:0] ppu_sel_adr;
    logic       dma_req, dma_grant, dma_slot_done;
    logic [7:0] dma_page_eff;

    assign slot_idle   = (slot_st_q == S_IDLE);

    // A fresh pulse is served in the same clock it arrives when the slot is free
    assign cpu_req     = cpu_rd | cpu_wr;
    assign cpu_any     = cpu_req | cpu_pend_q;
    assign cpu_sel_we  = cpu_req ? cpu_wr : cpu_we_q;
    assign cpu_sel_adr = cpu_req ? cpu_adr : cpu_adr_q;
    assign cpu_sel_din = cpu_req ? cpu_din : cpu_din_q;
    assign cpu_blocked = dma_active_q | ppu_lock;

    assign ppu_any     = ppu_rd | ppu_pend_q;
    assign ppu_sel_adr = ppu_rd ? ppu_adr : ppu_adr_q;

    // A retrigger in the same clock cancels the pending DMA write
    assign dma_req   = !dma_trig && ((dma_st_q == D_LATCH) || (dma_st_q == D_WRITE));
    assign dma_grant = slot_idle && dma_req;
    assign ppu_grant = slot_idle && ppu_any && !dma_active_q && !dma_req;
    assign cpu_grant = slot_idle && cpu_any && !cpu_blocked && !dma_req && !ppu_grant;

    // Blocked requests are answered from the pending flag, one clock after the pulse
    assign cpu_drop = cpu_pend_q && cpu_blocked;
    assign ppu_drop = ppu_pend_q && dma_active_q;

    assign dma_slot_done = (slot_st_q == S_RELEASE) && (slot_own_q == OWN_DMA);
    assign dma_page_eff  = (dma_page >= 8'hE0) ? (dma_page - 8'h20) : dma_page;

    always_comb begin
        slot_st_d   = slot_st_q;
        slot_own_d  = slot_own_q;
        slot_we_d   = slot_we_q;
        oam_adr_d   = oam_adr_q;
        oam_din_d   = oam_din_q;
        oam_read_d  = 1'b0;
        oam_write_d = 1'b0;
        cpu_dout_d  = cpu_dout_q;
        cpu_done_d  = 1'b0;
        ppu_dout_d  = ppu_dout_q;
        ppu_valid_d = 1'b0;

        unique case (slot_st_q)
            S_IDLE: begin
                if (dma_grant) begin
                    slot_st_d   = S_STROBE;
                    slot_own_d  = OWN_DMA;
                    slot_we_d   = 1'b1;
                    oam_write_d = 1'b1;
                    oam_adr_d   = dma_idx_q;
                    oam_din_d   = (dma_st_q == D_LATCH) ? ext_din : dma_data_q;
                end else if (ppu_grant) begin
                    slot_st_d   = S_STROBE;
                    slot_own_d  = OWN_PPU;
                    slot_we_d   = 1'b0;
                    oam_read_d  = 1'b1;
                    oam_adr_d   = ppu_sel_adr;
                end else if (cpu_grant) begin
                    slot_st_d   = S_STROBE;
                    slot_own_d  = OWN_CPU;
                    slot_we_d   = cpu_sel_we;
                    oam_read_d  = !cpu_sel_we;
                    oam_write_d = cpu_sel_we;
                    oam_adr_d   = cpu_sel_adr;
                    if (cpu_sel_we) begin
                        oam_din_d = cpu_sel_din;
                    end
                end
            end
            S_STROBE: begin
                slot_st_d = S_RELEASE;
            end
            S_RELEASE: begin
                slot_st_d = S_IDLE;
                if (slot_own_q == OWN_PPU) begin
                    ppu_valid_d = 1'b1;
                    ppu_dout_d  = oam_dout;
                end else if (slot_own_q == OWN_CPU) begin
                    cpu_done_d = 1'b1;
                    if (!slot_we_q) begin
                        cpu_dout_d = oam_dout;
                    end
                end
            end
            default: begin
                slot_st_d = S_IDLE;
            end
        endcase

        if (cpu_drop) begin
            cpu_done_d = 1'b1;
            if (!cpu_we_q) begin
                cpu_dout_d = 8'hFF;
            end
        end
        if (ppu_drop) begin
            ppu_valid_d = 1'b1;
            ppu_dout_d  = 8'hFF;
        end
    end

    always_comb begin
        cpu_pend_d = cpu_pend_q;
        cpu_we_d   = cpu_we_q;
        cpu_adr_d  = cpu_adr_q;
        cpu_din_d  = cpu_din_q;
        if (cpu_grant || cpu_drop) begin
            cpu_pend_d = 1'b0;
        end
        if (cpu_req && !cpu_grant) begin
            cpu_pend_d = 1'b1;
            cpu_we_d   = cpu_wr;
            cpu_adr_d  = cpu_adr;
            cpu_din_d  = cpu_din;
        end

        ppu_pend_d = ppu_pend_q;
        ppu_adr_d  = ppu_adr_q;
        if (ppu_grant || ppu_drop) begin
            ppu_pend_d = 1'b0;
        end
        if (ppu_rd && !ppu_grant) begin
            ppu_pend_d = 1'b1;
            ppu_adr_d  = ppu_adr;
        end
    end

    always_comb begin
        dma_st_d     = dma_st_q;
        dma_page_d   = dma_page_q;
        dma_idx_d    = dma_idx_q;
        dma_data_d   = dma_data_q;
        dma_active_d = dma_active_q;
        restart_d    = restart_q;
        setup_cnt_d  = setup_cnt_q;

        unique case (dma_st_q)
            D_IDLE: begin
            end
            D_SETUP: begin
                if (setup_cnt_q == 8'd0) begin
                    dma_st_d = D_FETCH;
                end else begin
                    setup_cnt_d = setup_cnt_q - 8'd1;
                end
            end
            D_FETCH: begin
                dma_st_d = D_LATCH;
            end
            D_LATCH: begin
                dma_data_d = ext_din;
                dma_st_d   = D_WRITE;
            end
            D_WRITE: begin
                if (dma_slot_done) begin
                    if (restart_q) begin
                        restart_d   = 1'b0;
                        dma_st_d    = D_SETUP;
                        setup_cnt_d = SETUP_INI;
                    end else if (dma_idx_q == LAST_IDX) begin
                        dma_st_d     = D_IDLE;
                        dma_active_d = 1'b0;
                    end else begin
                        dma_idx_d = dma_idx_q + 8'd1;
                        dma_st_d  = D_FETCH;
                    end
                end
            end
            default: begin
                dma_st_d = D_IDLE;
            end
        endcase

        // The slot already holds its address and data, so page/index may change now
        if (dma_trig) begin
            dma_page_d   = dma_page_eff;
            dma_idx_d    = 8'd0;
            dma_active_d = 1'b1;
            if ((slot_st_q == S_STROBE) && (slot_own_q == OWN_DMA)) begin
                restart_d = 1'b1;
            end else begin
                restart_d   = 1'b0;
                dma_st_d    = D_SETUP;
                setup_cnt_d = SETUP_INI;
            end
        end

        ext_rd_d  = (dma_st_d == D_FETCH);
        ext_adr_d = ext_rd_d ? {dma_page_d, dma_idx_d} : ext_adr_q;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            slot_st_q    <= S_IDLE;
            slot_own_q   <= OWN_DMA;
            slot_we_q    <= 1'b0;
            oam_adr_q    <= 8'h00;
            oam_din_q    <= 8'h00;
            oam_read_q   <= 1'b0;
            oam_write_q  <= 1'b0;
            cpu_dout_q   <= 8'hFF;
            cpu_done_q   <= 1'b0;
            ppu_dout_q   <= 8'hFF;
            ppu_valid_q  <= 1'b0;
            cpu_pend_q   <= 1'b0;
            cpu_we_q     <= 1'b0;
            cpu_adr_q    <= 8'h00;
            cpu_din_q    <= 8'h00;
            ppu_pend_q   <= 1'b0;
            ppu_adr_q    <= 8'h00;
            dma_st_q     <= D_IDLE;
            dma_page_q   <= 8'h00;
            dma_idx_q    <= 8'h00;
            dma_data_q   <= 8'h00;
            dma_active_q <= 1'b0;
            restart_q    <= 1'b0;
            setup_cnt_q  <= 8'h00;
            ext_adr_q    <= 16'h0000;
            ext_rd_q     <= 1'b0;
        end else begin
            slot_st_q    <= slot_st_d;
            slot_own_q   <= slot_own_d;
            slot_we_q    <= slot_we_d;
            oam_adr_q    <= oam_adr_d;
            oam_din_q    <= oam_din_d;
            oam_read_q   <= oam_read_d;
            oam_write_q  <= oam_write_d;
            cpu_dout_q   <= cpu_dout_d;
            cpu_done_q   <= cpu_done_d;
            ppu_dout_q   <= ppu_dout_d;
            ppu_valid_q  <= ppu_valid_d;
            cpu_pend_q   <= cpu_pend_d;
            cpu_we_q     <= cpu_we_d;
            cpu_adr_q    <= cpu_adr_d;
            cpu_din_q    <= cpu_din_d;
            ppu_pend_q   <= ppu_pend_d;
            ppu_adr_q    <= ppu_adr_d;
            dma_st_q     <= dma_st_d;
            dma_page_q   <= dma_page_d;
            dma_idx_q    <= dma_idx_d;
            dma_data_q   <= dma_data_d;
            dma_active_q <= dma_active_d;
            restart_q    <= restart_d;
            setup_cnt_q  <= setup_cnt_d;
            ext_adr_q    <= ext_adr_d;
            ext_rd_q     <= ext_rd_d;
        end
    end

    assign cpu_dout   = cpu_dout_q;
    assign cpu_done   = cpu_done_q;
    assign ppu_dout   = ppu_dout_q;
    assign ppu_valid  = ppu_valid_q;
    assign dma_active = dma_active_q;
    assign ext_adr    = ext_adr_q;
    assign ext_rd     = ext_rd_q;
    assign oam_adr    = oam_adr_q;
    assign oam_din    = oam_din_q;
    assign oam_read   = oam_read_q;
    assign oam_write  = oam_write_q;

endmodule

// File: doc/lr35902_oam_ctrl.md
Name: lr35902_oam_ctrl

Overview:
- Sequences and arbitrates every access to the 256x8 OAM sprite RAM.
- Three requesters share it: the OAM DMA engine (triggered by the FF46 register write), the PPU sprite scan, and the CPU (FE00–FE9F).
- Generates the RAM's level-sensitive strobes: read commits on the rising edge of oam_read; write commits on the falling edge of oam_write.
- Contains the DMA copy engine, which fetches 160 bytes from the external bus.

Parameters:
- OAM_SIZE, 160, number of bytes copied per DMA and the valid OAM range.
- SETUP_CYCLES, 1, idle clocks between dma_trig and the first fetch.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- nreset  in  1  asynchronous, active-low reset.
- cpu_adr  in  8  OAM offset (FE00 page low byte).
- cpu_rd  in  1  1-clk read request pulse.
- cpu_wr  in  1  1-clk write request pulse.
- cpu_din  in  8  write data.
- cpu_dout  out  8  read data.
- cpu_done  out  1  1-clk completion pulse.
- ppu_lock  in  1  PPU in mode 2/3; CPU is blocked.
- ppu_rd  in  1  1-clk scan read request.
- ppu_adr  in  8  scan address.
- ppu_dout  out  8  scan data.
- ppu_valid  out  1  1-clk pulse; ppu_dout valid.
- dma_trig  in  1  1-clk pulse on FF46 write.
- dma_page  in  8  source page.
- dma_active  out  1  high while a copy is running.
- ext_adr  out  16  external bus address.
- ext_rd  out  1  external read strobe.
- ext_din  in  8  external read data.
- oam_adr  out  8  RAM address.
- oam_din  out  8  RAM write data.
- oam_read  out  1  RAM read strobe.
- oam_write  out  1  RAM write strobe.
- oam_dout  in  8  RAM read data.

Behaviour:
- Reset values:
  - All outputs 0 except cpu_dout = 8'hFF and ppu_dout = 8'hFF.
  - Slot FSM in S_IDLE; DMA FSM in D_IDLE; pending flags cleared.
- Reset is asynchronous and aborts any DMA or slot immediately; OAM may hold a partial copy.
- Slot FSM, shared by all requesters: S_IDLE -> S_STROBE -> S_RELEASE -> S_IDLE.
  - S_STROBE: oam_adr and oam_din are driven, and oam_read or oam_write is high.
  - S_RELEASE: strobe low, adr/din held stable.
  - Read data is sampled from oam_dout at the end of S_RELEASE.
  - A slot takes 2 clocks; a new slot may start in the clock after S_RELEASE.
  - Strobes are registered and glitch-free; read and write strobes are never high together.
- Arbitration, evaluated in S_IDLE, fixed priority: DMA write > PPU read > CPU.
- Each requester has a one-deep pending flag, set by its request pulse. A requester must not pulse again before its done/valid pulse; if it does, the later request overwrites the pending one.
- CPU access:
  - If dma_active or ppu_lock is high when the request is granted or evaluated, no slot is used. cpu_done pulses 2 clocks after the request; reads return cpu_dout = FF; writes are dropped.
  - Otherwise a slot runs. cpu_done pulses in the clock after S_RELEASE, and for reads cpu_dout is latched data.
  - Writes with cpu_adr >= OAM_SIZE still run a slot; the RAM ignores them.
- PPU read:
  - While dma_active, ppu_valid pulses 2 clocks after ppu_rd with ppu_dout = FF; no slot is used.
  - Otherwise a slot runs, and ppu_valid and data follow as for the CPU.
- DMA FSM states: D_IDLE, D_SETUP, D_FETCH, D_LATCH, D_WRITE.
  - dma_trig: latches the source page, clears the index to 0, raises dma_active, and enters D_SETUP for SETUP_CYCLES clocks.
  - Source page remap: if dma_page >= E0, the latched page is dma_page - 20.
  - D_FETCH (1 clk): ext_adr = {page, index}, ext_rd = 1.
  - D_LATCH (1 clk): ext_rd = 0; ext_din is captured at the end of this clock.
  - D_WRITE: requests a write slot with oam_adr = index and the captured data.
    - DMA has top priority, but an in-progress CPU/PPU slot finishes first.
    - After the slot's S_RELEASE: if index = OAM_SIZE-1, go to D_IDLE and drop dma_active; otherwise increment index and go to D_FETCH.
  - Minimum duration with no contention: SETUP_CYCLES + 4*OAM_SIZE = 641 clocks from trig to dma_active falling.
  - dma_trig during an active DMA restarts the copy from index 0 with the new page after the current slot finishes. dma_active stays high throughout.
- ext_adr holds its last value when idle; ext_rd is high only in D_FETCH.

Test Plan:
- CPU write then read, both with ppu_lock = 0:
  - cpu_wr adr 05, din 3C -> oam_write high 1 clk, low 1 clk; cpu_done at +3.
  - cpu_rd adr 05 -> cpu_dout = 3C with cpu_done.
- dma_trig, page C1, ext returns the low address byte XOR A5 -> ext_rd pulses at C100..C19F.
  - OAM[i] = i^A5 for i in 0..159.
  - dma_active falls exactly 641 clocks after the trig.
- dma_page FE -> ext_adr runs DE00..DE9F.
- cpu_rd during DMA, and during ppu_lock -> cpu_dout = FF, cpu_done at +2, no oam_read pulse.
- cpu_wr during DMA -> OAM unchanged.
- PPU and CPU request in the same clock, ppu_lock = 0 -> PPU slot first, CPU slot immediately after.
- ppu_rd during DMA -> ppu_dout = FF.
- Restart and reset cases:
  - Retrigger at byte 50 with page C3 -> the copy restarts from index 0 and OAM ends with the C3 data.
  - nreset low mid-DMA -> all outputs go to reset values asynchronously.
